// File: rtl/dot_tracker_pkg.sv
// Shared encodings and helpers for the dot tracker: tile kinds, FSM states,
// and the pixel-to-tile coordinate conversion.
package dot_tracker_pkg;

  typedef enum logic [1:0] {
    TK_EMPTY  = 2'd0,
    TK_DOT    = 2'd1,
    TK_PELLET = 2'd2,
    TK_RSVD   = 2'd3
  } tile_kind_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_TRACK = 2'd1,
    ST_READ  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  function automatic logic [15:0] coord_to_tile(input logic [15:0] coord, input int tile_log2);
    return coord >> tile_log2;
  endfunction

endpackage

// File: rtl/eaten_bitmap_ram.sv
// Simple dual-port bitmap RAM: port A read/write, port B read-only, both with
// registered read. Read-first: a read of the row being written returns the old word.
module eaten_bitmap_ram #(
  parameter int W  = 19,
  parameter int D  = 23,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          i_we_a,
  input  logic [AW-1:0] i_addr_a,
  input  logic [W-1:0]  i_wdata_a,
  output logic [W-1:0]  o_rdata_a,
  input  logic [AW-1:0] i_addr_b,
  output logic [W-1:0]  o_rdata_b
);

  logic [W-1:0] r_mem [0:D-1];

  always_ff @(posedge clk) begin
    o_rdata_a <= r_mem[i_addr_a];
    o_rdata_b <= r_mem[i_addr_b];
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
  end

endmodule

// File: rtl/dot_tracker_grid.sv
// Per-tile eaten bitmap with dot/pellet scoring and eat counting.
// Optional level-complete flag enabled by defining DOT_TRACKER_LEVEL_DONE_EN.
module dot_tracker_grid
  import dot_tracker_pkg::*;
#(
  parameter int GRID_W     = 19,
  parameter int GRID_H     = 23,
  parameter int TILE_LOG2  = 4,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int SCORE_W    = 10,
  parameter int DOT_PTS    = 1,
  parameter int PELLET_PTS = 5
`ifdef DOT_TRACKER_LEVEL_DONE_EN
  ,
  parameter int TOTAL_DOTS = 244
`endif
) (
  input  logic                                  clk_100mhz,
  input  logic                                  reset,
  input  logic [1:0]                            map_num,
  input  logic [X_W-1:0]                        pacman_x,
  input  logic [Y_W-1:0]                        pacman_y,
  input  logic [1:0]                            tile_kind,
  input  logic [X_W-1:0]                        scan_x,
  input  logic [Y_W-1:0]                        scan_y,
  output logic                                  hide_dot,
  output logic [SCORE_W-1:0]                    score,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0]    dots_eaten,
  output logic                                  pellet_pulse,
  output logic                                  busy
`ifdef DOT_TRACKER_LEVEL_DONE_EN
  ,
  output logic                                  level_done
`endif
);

  localparam int TXW = X_W - TILE_LOG2;
  localparam int TYW = Y_W - TILE_LOG2;
  localparam int AW  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int DW  = $clog2(GRID_W * GRID_H + 1);

  state_e             r_state, w_state_next;
  logic [1:0]         r_prev_map;
  logic [AW-1:0]      r_row;
  logic [TXW-1:0]     r_tx, r_last_tx, r_scan_tx;
  logic [TYW-1:0]     r_ty, r_last_ty;
  logic [1:0]         r_kind;
  logic [SCORE_W-1:0] r_score;
  logic [DW-1:0]      r_dots;
  logic               r_pulse, r_scan_ok;

  logic [TXW-1:0]     w_p_tx, w_s_tx;
  logic [TYW-1:0]     w_p_ty, w_s_ty;
  logic               w_p_aligned, w_p_in, w_s_in, w_map_chg, w_qual, w_level_block;
  logic               w_we, w_eat, w_start, w_hit;
  logic [AW-1:0]      w_addr_a, w_addr_b;
  logic [GRID_W-1:0]  w_wdata, w_mask, w_rdata_a, w_rdata_b;
  logic [SCORE_W:0]   w_sum;

  assign w_p_tx      = TXW'(coord_to_tile(16'(pacman_x), TILE_LOG2));
  assign w_p_ty      = TYW'(coord_to_tile(16'(pacman_y), TILE_LOG2));
  assign w_s_tx      = TXW'(coord_to_tile(16'(scan_x), TILE_LOG2));
  assign w_s_ty      = TYW'(coord_to_tile(16'(scan_y), TILE_LOG2));
  assign w_p_aligned = (pacman_x[TILE_LOG2-1:0] == '0) && (pacman_y[TILE_LOG2-1:0] == '0);
  assign w_p_in      = (int'(w_p_tx) < GRID_W) && (int'(w_p_ty) < GRID_H);
  assign w_s_in      = (int'(w_s_tx) < GRID_W) && (int'(w_s_ty) < GRID_H);
  assign w_map_chg   = (map_num != r_prev_map);
  assign w_qual      = w_p_aligned && w_p_in && !w_level_block
                       && ((tile_kind == TK_DOT) || (tile_kind == TK_PELLET))
                       && ((w_p_tx != r_last_tx) || (w_p_ty != r_last_ty));

  assign w_mask  = GRID_W'(1) << r_tx;
  assign w_hit   = |(w_rdata_a & w_mask);
  assign w_sum   = {1'b0, r_score} + ((r_kind == TK_PELLET) ? (SCORE_W+1)'(PELLET_PTS)
                                                            : (SCORE_W+1)'(DOT_PTS));
  // Out-of-grid scan rows are never looked up; address 0 keeps the RAM index in range.
  assign w_addr_b = w_s_in ? AW'(w_s_ty) : '0;

  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_eat        = 1'b0;
    w_start      = 1'b0;
    w_addr_a     = AW'(r_ty);
    w_wdata      = w_rdata_a | w_mask;
    case (r_state)
      ST_CLEAR: begin
        w_addr_a = r_row;
        w_wdata  = '0;
        w_we     = 1'b1;
        if (r_row == AW'(GRID_H - 1)) w_state_next = ST_TRACK;
      end
      ST_TRACK: begin
        w_addr_a = w_p_in ? AW'(w_p_ty) : '0;
        if (w_qual) begin
          w_start      = 1'b1;
          w_state_next = ST_READ;
        end
      end
      ST_READ:  w_state_next = ST_CHECK;
      ST_CHECK: begin
        if (!w_hit) begin
          w_we  = 1'b1;
          w_eat = 1'b1;
        end
        w_state_next = ST_TRACK;
      end
      default:  w_state_next = ST_CLEAR;
    endcase
    // A map switch aborts whatever is in flight, including a pending write.
    if (w_map_chg) begin
      w_state_next = ST_CLEAR;
      w_we         = 1'b0;
      w_eat        = 1'b0;
      w_start      = 1'b0;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) r_state <= ST_CLEAR;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_100mhz) begin
    r_prev_map <= map_num;
    if (reset) begin
      r_row     <= '0;
      r_score   <= '0;
      r_dots    <= '0;
      r_pulse   <= 1'b0;
      r_last_tx <= '1;
      r_last_ty <= '1;
      r_tx      <= '0;
      r_ty      <= '0;
      r_kind    <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (w_map_chg) begin
        r_row     <= '0;
        r_dots    <= '0;
        r_last_tx <= '1;
        r_last_ty <= '1;
      end else begin
        if (r_state == ST_CLEAR) r_row <= r_row + AW'(1);
        if (w_start) begin
          r_tx   <= w_p_tx;
          r_ty   <= w_p_ty;
          r_kind <= tile_kind;
        end
        if (w_eat) begin
          r_score   <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
          r_dots    <= r_dots + DW'(1);
          r_pulse   <= (r_kind == TK_PELLET);
          r_last_tx <= r_tx;
          r_last_ty <= r_ty;
        end
      end
    end
  end

  // Scan lookups issued while clearing may return stale words, so they stay hidden.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_scan_tx <= '0;
      r_scan_ok <= 1'b0;
    end else begin
      r_scan_tx <= w_s_tx;
      r_scan_ok <= w_s_in && (r_state != ST_CLEAR);
    end
  end

`ifdef DOT_TRACKER_LEVEL_DONE_EN
  logic r_level_done;
  always_ff @(posedge clk_100mhz) begin
    if (reset || w_map_chg) r_level_done <= 1'b0;
    else if (w_eat && ((r_dots + DW'(1)) == DW'(TOTAL_DOTS))) r_level_done <= 1'b1;
  end
  assign level_done    = r_level_done;
  assign w_level_block = r_level_done;
`else
  assign w_level_block = 1'b0;
`endif

  eaten_bitmap_ram #(
    .W  (GRID_W),
    .D  (GRID_H),
    .AW (AW)
  ) u_ram (
    .clk       (clk_100mhz),
    .i_we_a    (w_we),
    .i_addr_a  (w_addr_a),
    .i_wdata_a (w_wdata),
    .o_rdata_a (w_rdata_a),
    .i_addr_b  (w_addr_b),
    .o_rdata_b (w_rdata_b)
  );

  assign busy         = (r_state == ST_CLEAR);
  assign hide_dot     = r_scan_ok && !busy && |(w_rdata_b & (GRID_W'(1) << r_scan_tx));
  assign score        = r_score;
  assign dots_eaten   = r_dots;
  assign pellet_pulse = r_pulse;

endmodule

// File: tb/tb_dot_tracker_grid.sv
// Scoreboard bench for dot_tracker_grid: stimulus queues expected eat results,
// a monitor pops and compares whenever dots_eaten advances.
module tb_dot_tracker_grid;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int SCORE_W = 10;
  localparam int DW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [1:0]         map_num;
  logic [X_W-1:0]     pacman_x, scan_x;
  logic [Y_W-1:0]     pacman_y, scan_y;
  logic [1:0]         tile_kind;
  logic               hide_dot, pellet_pulse, busy;
  logic [SCORE_W-1:0] score;
  logic [DW-1:0]      dots_eaten;

  dot_tracker_grid dut (
    .clk_100mhz   (clk),
    .reset        (reset),
    .map_num      (map_num),
    .pacman_x     (pacman_x),
    .pacman_y     (pacman_y),
    .tile_kind    (tile_kind),
    .scan_x       (scan_x),
    .scan_y       (scan_y),
    .hide_dot     (hide_dot),
    .score        (score),
    .dots_eaten   (dots_eaten),
    .pellet_pulse (pellet_pulse),
    .busy         (busy)
  );

  typedef struct {
    int score;
    int dots;
    int pulse;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  int exp_score = 0;
  int exp_dots = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
      $display("ok   %s: got %0d", name, act);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_eat(input int pts, input int pulse);
    exp_score = (exp_score + pts > 1023) ? 1023 : exp_score + pts;
    exp_dots++;
    sb_q.push_back('{exp_score, exp_dots, pulse, cyc + 3});
  endtask

  task automatic move(input int x, input int y, input int kind);
    pacman_x  = X_W'(x);
    pacman_y  = Y_W'(y);
    tile_kind = 2'(kind);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk({name, "_timeout"}, sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic scan(input string name, input int x, input int y, input int exp);
    scan_x = X_W'(x);
    scan_y = Y_W'(y);
    @(negedge clk);
    chk(name, int'(hide_dot), exp);
  endtask

  // Monitor: an eat is any cycle where dots_eaten advances by one.
  initial begin
    int prev_dots = 0;
    int prev_pellet = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_dots = 0;
        prev_pellet = 0;
      end else begin
        if (prev_pellet != 0) chk("pulse_width", int'(pellet_pulse), 0);
        prev_pellet = 0;
        if (int'(dots_eaten) == prev_dots + 1) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_eat", int'(dots_eaten), prev_dots);
          end else begin
            e = sb_q.pop_front();
            chk("eat_score", int'(score), e.score);
            chk("eat_dots", int'(dots_eaten), e.dots);
            chk("eat_pulse", int'(pellet_pulse), e.pulse);
            chk("eat_cycle", cyc, e.cyc);
            prev_pellet = e.pulse;
          end
        end else if (pellet_pulse) begin
          chk("stray_pulse", int'(pellet_pulse), 0);
        end
        prev_dots = int'(dots_eaten);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    map_num = 2'd0;
    move(0, 0, 0);
    scan_x = '0;
    scan_y = '0;
    repeat (3) @(negedge clk);
    chk("reset_score", int'(score), 0);
    chk("reset_dots", int'(dots_eaten), 0);
    chk("reset_pulse", int'(pellet_pulse), 0);
    chk("reset_hide", int'(hide_dot), 0);
    chk("reset_busy", int'(busy), 1);

    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    chk("clear_cycles", n, 23);
    scan("hide_after_clear_a", 0, 0, 0);
    scan("hide_after_clear_b", 37, 50, 0);

    // First dot at tile (2,3)
    move(32, 48, 1);
    expect_eat(1, 0);
    drain("dot1");
    chk("dot1_score", int'(score), 1);
    scan("hide_eaten", 37, 50, 1);
    scan("hide_neighbour", 48, 48, 0);
    scan("hide_out_of_grid", 320, 0, 0);

    // Holding, leaving and returning must not re-score
    repeat (100) @(negedge clk);
    chk("hold_score", int'(score), 1);
    move(48, 48, 0);
    repeat (5) @(negedge clk);
    move(32, 48, 1);
    repeat (10) @(negedge clk);
    chk("return_score", int'(score), 1);

    // Pellet at tile (4,1)
    move(64, 16, 2);
    expect_eat(5, 1);
    drain("pellet");
    chk("pellet_score", int'(score), 6);

    // Unaligned, out-of-grid x, out-of-grid y, reserved kind
    move(33, 48, 1);
    repeat (6) @(negedge clk);
    move(320, 0, 1);
    repeat (6) @(negedge clk);
    move(0, 368, 1);
    repeat (6) @(negedge clk);
    move(96, 96, 3);
    repeat (6) @(negedge clk);
    chk("ignore_score", int'(score), 6);
    chk("ignore_dots", int'(dots_eaten), 2);

    move(16, 32, 1);
    expect_eat(1, 0);
    drain("dot3");

    // Map change lands on the CHECK cycle of the fourth eat
    move(48, 64, 1);
    @(negedge clk);
    @(negedge clk);
    map_num = 2'd1;
    @(negedge clk);
    tile_kind = 2'd0;
    chk("abort_busy", int'(busy), 1);
    chk("abort_dots", int'(dots_eaten), 0);
    chk("abort_score", int'(score), 7);
    n = 1;
    while (busy && n < 40) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("reclear_cycles", n, 23);
    exp_dots = 0;
    scan("cleared_dot1", 32, 48, 0);
    scan("cleared_pellet", 64, 16, 0);
    scan("cleared_dot3", 16, 32, 0);
    scan("aborted_tile", 48, 64, 0);

    // Pellets across the grid until the score saturates
    for (int i = 0; i < 205; i++) begin
      move((i % 19) * 16, (i / 19) * 16, 2);
      expect_eat(5, 1);
      drain("sat");
    end
    chk("sat_score", int'(score), 1023);
    chk("sat_dots", int'(dots_eaten), 205);
    scan("hide_last_col", 288, 0, 1);
    scan("hide_row10", 0, 160, 1);
    scan("hide_uneaten", 288, 160, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
